// File: rtl/dmem_access_sequencer_pkg.sv
// ----------------------------------------------------------------------------------
// dmem_access_sequencer_pkg: size codes, FSM states, request legality. Rev 1.0
// ----------------------------------------------------------------------------------
`default_nettype none

package dmem_access_sequencer_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    DS_IDLE   = 2'd0,
    DS_LD_CAP = 2'd1,
    DS_RMW_WR = 2'd2,
    DS_DONE   = 2'd3
  } ds_state_e;

  // A request is dropped when its size is illegal, it is misaligned, or it is both a load and a store.
  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    ok = !(rd && wr);
    case (size)
      SZ_BYTE: ;
      SZ_HALF: if (lane[0]) ok = 1'b0;
      SZ_WORD: if (lane != 2'b00) ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_access_sequencer_lanes.sv
// ----------------------------------------------------------------------------------
// dmem_access_sequencer_lanes: little-endian lane extract (loads) and merge (RMW). Rev 1.0
// ----------------------------------------------------------------------------------
`default_nettype none

module dmem_access_sequencer_lanes
  import dmem_access_sequencer_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  always_comb begin
    extracted = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: begin
            extracted = {24'b0, word[7:0]};
            merged    = {word[31:8], wdata[7:0]};
          end
          2'd1: begin
            extracted = {24'b0, word[15:8]};
            merged    = {word[31:16], wdata[7:0], word[7:0]};
          end
          2'd2: begin
            extracted = {24'b0, word[23:16]};
            merged    = {word[31:24], wdata[7:0], word[15:0]};
          end
          default: begin
            extracted = {24'b0, word[31:24]};
            merged    = {wdata[7:0], word[23:0]};
          end
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          extracted = {16'b0, word[31:16]};
          merged    = {wdata[15:0], word[15:0]};
        end else begin
          extracted = {16'b0, word[15:0]};
          merged    = {word[31:16], wdata[15:0]};
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_access_sequencer.sv
// ----------------------------------------------------------------------------------
// dmem_access_sequencer: MEM-stage load/store sequencer for a single-port sync-read RAM. Rev 1.0
// ----------------------------------------------------------------------------------
`default_nettype none

module dmem_access_sequencer
  import dmem_access_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  ds_state_e         state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              is_load_q, is_load_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       lane_ext;
  logic [31:0]       lane_merged;
  logic              legal;
  logic              unused_addr_hi;

  assign legal          = req_legal(req_read, req_write, size, addr[1:0]);
  assign unused_addr_hi = ^addr[31:ADDR_W+2];
  assign rdata          = rdata_q;

  dmem_access_sequencer_lanes u_lanes (
    .word      (ram_rdata),
    .lane      (lane_q),
    .size      (size_q),
    .wdata     (wdata_q),
    .extracted (lane_ext),
    .merged    (lane_merged)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    size_d    = size_q;
    is_load_d = is_load_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    ram_we    = 1'b0;
    err       = 1'b0;
    rvalid    = 1'b0;
    ram_addr  = waddr_q;
    ram_wdata = '0;
    case (state_q)
      DS_IDLE: begin
        ram_addr = '0;
        // Gating on rst keeps a request still sitting in MEM from re-arming stall/we during reset.
        if (!rst && (req_read || req_write)) begin
          if (!legal) begin
            err = 1'b1;
          end else begin
            ram_addr = addr[ADDR_W+1:2];
            if (req_write && size == SZ_WORD) begin
              ram_we    = 1'b1;
              ram_wdata = wdata;
            end else begin
              stall     = 1'b1;
              lane_d    = addr[1:0];
              size_d    = size;
              is_load_d = req_read;
              wdata_d   = wdata;
              waddr_d   = addr[ADDR_W+1:2];
              state_d   = req_read ? DS_LD_CAP : DS_RMW_WR;
            end
          end
        end
      end
      DS_LD_CAP: begin
        stall   = 1'b1;
        rdata_d = lane_ext;
        state_d = DS_DONE;
      end
      DS_RMW_WR: begin
        stall     = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = lane_merged;
        state_d   = DS_DONE;
      end
      DS_DONE: begin
        rvalid  = is_load_q;
        state_d = DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DS_IDLE;
      lane_q    <= 2'b00;
      size_q    <= SZ_BYTE;
      is_load_q <= 1'b0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      is_load_q <= is_load_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_sequencer.sv
// ----------------------------------------------------------------------------------
// tb_dmem_access_sequencer: directed + random checks against a word-array reference model. Rev 1.0
// ----------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_access_sequencer;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_read, req_write;
  logic [1:0]        size;
  logic [31:0]       addr, wdata;
  logic [31:0]       rdata;
  logic              rvalid, stall, err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] last_rdata;
  int checks = 0;
  int errors = 0;

  dmem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_read  (req_read),
    .req_write (req_write),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .stall     (stall),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic model_legal(input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic [31:0] a);
    if (rd && wr) return 1'b0;
    if (sz == 2'd3) return 1'b0;
    if (sz == 2'd1 && a[0]) return 1'b0;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_idle();
    req_read = 1'b0; req_write = 1'b0; size = 2'd0; addr = '0; wdata = '0;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one access (called at posedge+1) and checks it cycle by cycle against the model.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic ok, is_store;
    int sh, exp_stalls, stalls, wes;
    logic [31:0] m, exp_rd, exp_err;
    logic [ADDR_W-1:0] wi;
    bit done;
    ok         = model_legal(rd, wr, sz, a);
    is_store   = wr && ok;
    sh         = 8 * int'(a[1:0]);
    m          = lane_mask(sz);
    wi         = a[ADDR_W+1:2];
    exp_stalls = (ok && (rd || sz != 2'd2)) ? 2 : 0;
    exp_rd     = (rd && ok) ? ((ref_mem[wi] >> sh) & m) : last_rdata;
    req_read = rd; req_write = wr; size = sz; addr = a; wdata = wd;
    stalls = 0; wes = 0; done = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      exp_err = (c == 0 && !ok) ? 32'd1 : 32'd0;
      checks++;
      if ({31'b0, err} !== exp_err)
        $display("FAIL %s err: got %0b expected %0d (cycle %0d)", tag, err, exp_err, c);
      if ({31'b0, err} !== exp_err) errors++;
      if (ram_we === 1'b1) wes++;
      if (stall === 1'b1) begin
        stalls++;
        checks++;
        if (ram_addr !== wi || rvalid !== 1'b0) begin
          errors++;
          $display("FAIL %s stall-cycle: ram_addr=%0d rvalid=%0b expected ram_addr=%0d rvalid=0",
                   tag, ram_addr, rvalid, wi);
        end
      end else begin
        done = 1;
        if (ok && wr && sz == 2'd2) begin
          checks++;
          if (ram_addr !== wi || ram_wdata !== wd) begin
            errors++;
            $display("FAIL %s word-store: ram_addr=%0d wdata=%h expected %0d %h",
                     tag, ram_addr, ram_wdata, wi, wd);
          end
        end
        checks++;
        if (rvalid !== (rd && ok) || rdata !== exp_rd) begin
          errors++;
          $display("FAIL %s result: rvalid=%0b rdata=%h expected rvalid=%0b rdata=%h",
                   tag, rvalid, rdata, rd && ok, exp_rd);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done || stalls != exp_stalls || wes != (is_store ? 1 : 0)) begin
      errors++;
      $display("FAIL %s timing: done=%0b stalls=%0d writes=%0d expected stalls=%0d writes=%0d",
               tag, done, stalls, wes, exp_stalls, is_store ? 1 : 0);
    end
    last_rdata = exp_rd;
    if (is_store) begin
      ref_mem[wi] = (ref_mem[wi] & ~(m << sh)) | ((wd & m) << sh);
      checks++;
      if (mem[wi] !== ref_mem[wi]) begin
        errors++;
        $display("FAIL %s ram: RAM[%0d]=%h expected %h", tag, wi, mem[wi], ref_mem[wi]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (rdata !== 32'h0 || rvalid !== 1'b0 || err !== 1'b0 || stall !== 1'b0 ||
        ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdata=%h rvalid=%0b err=%0b stall=%0b we=%0b addr=%0d wdata=%h expected all 0",
               rdata, rvalid, err, stall, ram_we, ram_addr, ram_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rdata = 32'h0;
    idle_cycles(1);
  endtask

  task automatic test_word_store();
    access(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, "sw_0x10");
    checks++;
    if (mem[4] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_const: RAM[4]=%h expected deadbeef", mem[4]);
    end
  endtask

  task automatic test_load();
    access(1'b1, 1'b0, 2'd0, 32'h13, 32'h0, "lbu_0x13");
    checks++;
    if (rdata !== 32'h0000_00DE) begin
      errors++;
      $display("FAIL lbu_const: rdata=%h expected 000000de", rdata);
    end
    access(1'b1, 1'b0, 2'd1, 32'h12, 32'h0, "lhu_0x12");
    checks++;
    if (rdata !== 32'h0000_DEAD) begin
      errors++;
      $display("FAIL lhu_const: rdata=%h expected 0000dead", rdata);
    end
  endtask

  task automatic test_illegal();
    access(1'b1, 1'b0, 2'd1, 32'h11, 32'h0, "lhu_0x11_misaligned");
    access(1'b0, 1'b1, 2'd2, 32'h12, 32'h1111_1111, "sw_0x12_misaligned");
    access(1'b1, 1'b0, 2'd3, 32'h10, 32'h0, "size3");
    access(1'b1, 1'b1, 2'd2, 32'h10, 32'h2222_2222, "rd_and_wr");
    idle_cycles(1);
  endtask

  task automatic test_subword_store();
    access(1'b0, 1'b1, 2'd0, 32'h11, 32'h0000_0055, "sb_0x11");
    checks++;
    if (mem[4] !== 32'hDEAD_55EF) begin
      errors++;
      $display("FAIL sb_const: RAM[4]=%h expected dead55ef", mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 2'd1, 32'h10, 32'hFFFF_1234, "sh_0x10");
    access(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, "lw_0x10");
    checks++;
    if (rdata !== 32'hDEAD_1234 || mem[4] !== 32'hDEAD_1234) begin
      errors++;
      $display("FAIL b2b_const: rdata=%h RAM[4]=%h expected dead1234", rdata, mem[4]);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_rmw();
    req_read = 1'b0; req_write = 1'b1; size = 2'd0; addr = 32'h12; wdata = 32'hAA;
    @(posedge clk);
    #2;
    checks++;
    if (ram_we !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rmw_reach: ram_we=%0b stall=%0b expected 1 1", ram_we, stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rmw_reset: we=%0b stall=%0b err=%0b rvalid=%0b rdata=%h expected 0",
               ram_we, stall, err, rvalid, rdata);
    end
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    last_rdata = 32'h0;
    idle_cycles(1);
    checks++;
    if (mem[4] !== ref_mem[4]) begin
      errors++;
      $display("FAIL rmw_reset_ram: RAM[4]=%h expected %h", mem[4], ref_mem[4]);
    end
    access(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    int kind;
    for (int i = 0; i < 8; i++)
      access(1'b0, 1'b1, 2'd2, 32'h100 + 32'(4 * i), $urandom, "rand_preload");
    for (int i = 0; i < 80; i++) begin
      a    = {$urandom_range(0, 1) ? 20'($urandom) : 20'h0, 12'h100} +
             32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      if (kind < 5)      access(1'b1, 1'b0, sz, a, $urandom, "rand_load");
      else if (kind < 9) access(1'b0, 1'b1, sz, a, $urandom, "rand_store");
      else               access(1'b1, 1'b1, sz, a, $urandom, "rand_both");
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_load();
    test_illegal();
    test_subword_store();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
